// File: rtl/axil_sram_slave.sv
// AXI4-Lite SRAM slave: independent AW/W capture, per-byte strobes, SLVERR on
// out-of-range accesses, one outstanding read and one outstanding write.
module axil_sram_slave #(
    parameter int MEM_BYTES  = 532480,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SHIFT      = $clog2(STRB_WIDTH);
    localparam int DEPTH      = MEM_BYTES / STRB_WIDTH;
    localparam int IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_AW = 2'd1,
        HAVE_W  = 2'd2,
        RESP    = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    wr_state_t             wr_state_r;
    wr_state_t             wr_state_s;
    rd_state_t             rd_state_r;
    rd_state_t             rd_state_s;

    logic                  awready_r;
    logic                  wready_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic [1:0]            rresp_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    logic [ADDR_WIDTH-1:0] awaddr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [STRB_WIDTH-1:0] wstrb_r;

    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  b_hs_s;
    logic                  ar_hs_s;
    logic                  r_hs_s;
    logic                  commit_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [STRB_WIDTH-1:0] wr_strb_s;
    logic                  wr_in_range_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic                  rd_in_range_s;
    logic [IDX_W-1:0]      rd_idx_s;

    assign s_awready = awready_r;
    assign s_wready  = wready_r;
    assign s_bvalid  = bvalid_r;
    assign s_bresp   = bresp_r;
    assign s_arready = arready_r;
    assign s_rvalid  = rvalid_r;
    assign s_rresp   = rresp_r;
    assign s_rdata   = rdata_r;

    assign aw_hs_s = s_awvalid && awready_r;
    assign w_hs_s  = s_wvalid && wready_r;
    assign b_hs_s  = bvalid_r && s_bready;
    assign ar_hs_s = s_arvalid && arready_r;
    assign r_hs_s  = rvalid_r && s_rready;

    // The commit edge may coincide with either handshake, so bypass the capture registers.
    assign wr_addr_s     = aw_hs_s ? s_awaddr : awaddr_r;
    assign wr_data_s     = w_hs_s ? s_wdata : wdata_r;
    assign wr_strb_s     = w_hs_s ? s_wstrb : wstrb_r;
    assign wr_in_range_s = (wr_addr_s < MEM_LIMIT);
    assign wr_idx_s      = wr_addr_s[IDX_W+SHIFT-1:SHIFT];
    assign commit_s      = (wr_state_s == RESP) && (wr_state_r != RESP);

    assign rd_in_range_s = (s_araddr < MEM_LIMIT);
    assign rd_idx_s      = s_araddr[IDX_W+SHIFT-1:SHIFT];

    // Write FSM next-state decode.
    always_comb begin
        wr_state_s = wr_state_r;
        case (wr_state_r)
            IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    wr_state_s = RESP;
                end else if (aw_hs_s) begin
                    wr_state_s = HAVE_AW;
                end else if (w_hs_s) begin
                    wr_state_s = HAVE_W;
                end else begin
                    wr_state_s = IDLE;
                end
            end
            HAVE_AW: begin
                if (w_hs_s) begin
                    wr_state_s = RESP;
                end else begin
                    wr_state_s = HAVE_AW;
                end
            end
            HAVE_W: begin
                if (aw_hs_s) begin
                    wr_state_s = RESP;
                end else begin
                    wr_state_s = HAVE_W;
                end
            end
            RESP: begin
                if (b_hs_s) begin
                    wr_state_s = IDLE;
                end else begin
                    wr_state_s = RESP;
                end
            end
            default: wr_state_s = IDLE;
        endcase
    end

    // Write FSM state, registered readies, captured AW/W and the B channel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state_r <= IDLE;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            awaddr_r   <= {ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            wstrb_r    <= {STRB_WIDTH{1'b0}};
        end else begin
            wr_state_r <= wr_state_s;
            awready_r  <= (wr_state_s == IDLE) || (wr_state_s == HAVE_W);
            wready_r   <= (wr_state_s == IDLE) || (wr_state_s == HAVE_AW);
            if (aw_hs_s) begin
                awaddr_r <= s_awaddr;
            end
            if (w_hs_s) begin
                wdata_r <= s_wdata;
                wstrb_r <= s_wstrb;
            end
            if (commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_in_range_s ? RESP_OKAY : RESP_SLVERR;
            end else if (b_hs_s) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Byte-granular array write on the commit edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (commit_s && wr_in_range_s) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wr_strb_s[i]) begin
                    mem_r[wr_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
                end
            end
        end
    end

    // Read FSM next-state decode.
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_s = R_RESP;
                end else begin
                    rd_state_s = R_IDLE;
                end
            end
            R_RESP: begin
                if (r_hs_s) begin
                    rd_state_s = R_IDLE;
                end else begin
                    rd_state_s = R_RESP;
                end
            end
            default: rd_state_s = R_IDLE;
        endcase
    end

    // Read FSM state and R channel; the array read sees pre-commit data on a shared edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rresp_r    <= RESP_OKAY;
            rdata_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_state_r <= rd_state_s;
            arready_r  <= (rd_state_s == R_IDLE);
            if (ar_hs_s) begin
                rvalid_r <= 1'b1;
                rresp_r  <= rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
                rdata_r  <= rd_in_range_s ? mem_r[rd_idx_s] : {DATA_WIDTH{1'b0}};
            end else if (r_hs_s) begin
                rvalid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed self-checking bench for axil_sram_slave (32-bit bus, default depth).
module tb_axil_sram_slave;

    logic        clk;
    logic        resetn;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    int n_checks = 0;
    int n_pass   = 0;

    axil_sram_slave #(
        .MEM_BYTES (532480),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .s_awaddr (s_awaddr),
        .s_awvalid(s_awvalid),
        .s_awready(s_awready),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_wvalid (s_wvalid),
        .s_wready (s_wready),
        .s_bresp  (s_bresp),
        .s_bvalid (s_bvalid),
        .s_bready (s_bready),
        .s_araddr (s_araddr),
        .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .s_rdata  (s_rdata),
        .s_rresp  (s_rresp),
        .s_rvalid (s_rvalid),
        .s_rready (s_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drives one write; valids start aw_dly / w_dly cycles in, B is held off for hold cycles.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                            input int aw_dly, input int w_dly, input int hold,
                            output logic [1:0] resp);
        bit aw_pend;
        bit w_pend;
        bit hs_aw;
        bit hs_w;
        bit order_ok;
        int n;
        @(negedge clk);
        s_awaddr = a;
        s_wdata  = d;
        s_wstrb  = st;
        s_bready = (hold == 0);
        aw_pend  = 1'b1;
        w_pend   = 1'b1;
        order_ok = 1'b1;
        n = 0;
        while ((aw_pend || w_pend) && n < 40) begin
            s_awvalid = aw_pend && (n >= aw_dly);
            s_wvalid  = w_pend && (n >= w_dly);
            if (aw_pend != w_pend) begin
                if (s_awready != aw_pend || s_wready != w_pend) order_ok = 1'b0;
            end
            hs_aw = s_awvalid && s_awready;
            hs_w  = s_wvalid && s_wready;
            @(negedge clk);
            n++;
            if (hs_aw) aw_pend = 1'b0;
            if (hs_w) w_pend = 1'b0;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        check_eq("wr_handshake", {aw_pend, w_pend}, 2'b00);
        check_eq("wr_half_readies", order_ok, 1'b1);
        check_eq("bvalid_latency", s_bvalid, 1'b1);
        resp = s_bresp;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_eq("b_stable", {s_bvalid, s_bresp}, {1'b1, resp});
            check_eq("b_readies_low", {s_awready, s_wready}, 2'b00);
        end
        s_bready = 1'b1;
        @(negedge clk);
        check_eq("b_done", {s_bvalid, s_awready, s_wready}, 3'b011);
        s_bready = 1'b0;
    endtask

    // Drives one read; R is held off for hold cycles.
    task automatic do_read(input logic [31:0] a, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
        bit pend;
        bit hs;
        int n;
        @(negedge clk);
        s_araddr  = a;
        s_arvalid = 1'b1;
        s_rready  = (hold == 0);
        pend = 1'b1;
        n = 0;
        while (pend && n < 40) begin
            hs = s_arready;
            @(negedge clk);
            n++;
            if (hs) pend = 1'b0;
        end
        s_arvalid = 1'b0;
        check_eq("rd_handshake", pend, 1'b0);
        check_eq("rvalid_latency", s_rvalid, 1'b1);
        data = s_rdata;
        resp = s_rresp;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_eq("r_stable", {s_rvalid, s_rresp, s_rdata}, {1'b1, resp, data});
            check_eq("r_arready_low", s_arready, 1'b0);
        end
        s_rready = 1'b1;
        @(negedge clk);
        check_eq("r_done", {s_rvalid, s_arready}, 2'b01);
        s_rready = 1'b0;
    endtask

    logic [1:0]  resp;
    logic [31:0] rd;

    initial begin
        resetn = 1'b0;
        s_awaddr = 32'h0; s_awvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'h0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = 32'h0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata},
                 41'h0);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("readies_after_reset", {s_awready, s_wready, s_arready}, 3'b111);

        // Full write then read.
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp);
        check_eq("t1_bresp", resp, 2'b00);
        do_read(32'h10, 0, rd, resp);
        check_eq("t1_rdata", rd, 32'hDEADBEEF);
        check_eq("t1_rresp", resp, 2'b00);

        // All-zero strobe: OKAY, nothing written.
        do_write(32'h10, 32'h0, 4'h0, 0, 0, 0, resp);
        check_eq("zero_strb_bresp", resp, 2'b00);
        do_read(32'h10, 0, rd, resp);
        check_eq("zero_strb_rdata", rd, 32'hDEADBEEF);

        // Byte strobes, W three cycles ahead of AW, then AW ahead of W.
        do_write(32'h20, 32'h11223344, 4'hF, 0, 0, 0, resp);
        do_write(32'h20, 32'hAABBCCDD, 4'b0101, 3, 0, 0, resp);
        check_eq("t2_bresp", resp, 2'b00);
        do_read(32'h20, 0, rd, resp);
        check_eq("t2_rdata", rd, 32'h11BB33DD);
        do_write(32'h22, 32'h99000000, 4'b1000, 0, 2, 0, resp);
        do_read(32'h20, 0, rd, resp);
        check_eq("t2_aw_first_rdata", rd, 32'h99BB33DD);

        // Out of range at exactly MEM_BYTES; first and last words untouched.
        do_write(32'h0, 32'hA5A5A5A5, 4'hF, 0, 0, 0, resp);
        do_write(32'h81FFC, 32'h5A5A5A5A, 4'hF, 0, 0, 0, resp);
        do_write(32'h82000, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp);
        check_eq("oor_bresp", resp, 2'b10);
        do_read(32'h82000, 0, rd, resp);
        check_eq("oor_rdata", rd, 32'h0);
        check_eq("oor_rresp", resp, 2'b10);
        do_read(32'h0, 0, rd, resp);
        check_eq("word0_intact", rd, 32'hA5A5A5A5);
        do_read(32'h81FFC, 0, rd, resp);
        check_eq("last_word_intact", rd, 32'h5A5A5A5A);
        check_eq("last_word_rresp", resp, 2'b00);

        // Backpressure on both response channels.
        do_write(32'h30, 32'h0BADCAFE, 4'hF, 0, 0, 5, resp);
        check_eq("bp_bresp", resp, 2'b00);
        do_read(32'h30, 5, rd, resp);
        check_eq("bp_rdata", rd, 32'h0BADCAFE);

        // Collision: commit and read sample on the same edge.
        do_write(32'h40, 32'h0, 4'hF, 0, 0, 0, resp);
        @(negedge clk);
        check_eq("coll_readies", {s_awready, s_wready, s_arready}, 3'b111);
        s_awaddr = 32'h40; s_wdata = 32'hFFFFFFFF; s_wstrb = 4'hF;
        s_araddr = 32'h40;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        s_bready = 1'b1; s_rready = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        check_eq("coll_valids", {s_bvalid, s_rvalid}, 2'b11);
        check_eq("coll_rdata_old", s_rdata, 32'h0);
        @(negedge clk);
        s_bready = 1'b0; s_rready = 1'b0;
        do_read(32'h40, 0, rd, resp);
        check_eq("coll_rdata_new", rd, 32'hFFFFFFFF);

        // Reset while holding an address in HAVE_AW.
        do_write(32'h80, 32'hCAFEF00D, 4'hF, 0, 0, 0, resp);
        @(negedge clk);
        s_awaddr = 32'h80;
        s_awvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0;
        check_eq("have_aw_readies", {s_awready, s_wready}, 2'b01);
        resetn = 1'b0;
        #1;
        check_eq("midop_reset_outputs",
                 {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata},
                 41'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("readies_after_midop_reset", {s_awready, s_wready, s_arready}, 3'b111);
        do_write(32'h84, 32'h12345678, 4'hF, 2, 0, 0, resp);
        check_eq("post_reset_bresp", resp, 2'b00);
        do_read(32'h84, 0, rd, resp);
        check_eq("post_reset_new_word", rd, 32'h12345678);
        do_read(32'h80, 0, rd, resp);
        check_eq("held_addr_unused", rd, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
